// File: rtl/bitmap_encoder8.sv
// Bitmap encoder: accepts an 8-bit request bitmap and emits the index of each set bit, one beat per handshake.
// Latency: first beat is valid the cycle after the accepting edge; later beats follow one per consumed beat.
// Backpressure: out_ready low holds the current beat stable; in_ready is low throughout EMIT and while en or rst_n is low.
// Optional feature: define BITMAP_ENC_ZERO_REPORT_EN to emit a single out_zero beat for an all-zero bitmap.
module bitmap_encoder8 #(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       out_zero,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q;
    logic [7:0] pending_q;
    logic [2:0] out_q;
    logic       out_valid_q;
    logic       out_last_q;
`ifdef BITMAP_ENC_ZERO_REPORT_EN
    logic       out_zero_q;
`endif

    // Index of the set bit that goes out first, honouring the emit order.
    function automatic logic [2:0] pick_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit is set.
    function automatic logic single_bit(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    logic [7:0] in_idx_unused_guard;
    logic [7:0] remaining;
    logic [2:0] in_idx;
    logic [2:0] rem_idx;
    logic       in_single;
    logic       rem_single;

    // Next-beat candidates, both for a freshly accepted bitmap and for the bitmap minus the beat being consumed.
    always_comb begin
        in_idx_unused_guard = in;
        in_idx              = pick_idx(in_idx_unused_guard);
        in_single           = single_bit(in_idx_unused_guard);
        remaining           = pending_q & ~(8'd1 << out_q);
        rem_idx             = pick_idx(remaining);
        rem_single          = single_bit(remaining);
    end

    // Control FSM with registered beat outputs; abort on en low wins over a concurrent handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 8'd0;
            out_q       <= 3'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef BITMAP_ENC_ZERO_REPORT_EN
            out_zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && in_valid) begin
                        if (in != 8'd0) begin
                            pending_q   <= in;
                            state_q     <= EMIT;
                            out_valid_q <= 1'b1;
                            out_q       <= in_idx;
                            out_last_q  <= in_single;
                        end
`ifdef BITMAP_ENC_ZERO_REPORT_EN
                        else begin
                            // All-zero bitmap becomes a single reporting beat.
                            pending_q   <= 8'd0;
                            state_q     <= EMIT;
                            out_valid_q <= 1'b1;
                            out_q       <= 3'd0;
                            out_last_q  <= 1'b1;
                            out_zero_q  <= 1'b1;
                        end
`endif
                    end
                end
                EMIT: begin
                    if (!en || (out_ready && out_last_q)) begin
                        pending_q   <= 8'd0;
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_q       <= 3'd0;
                        out_last_q  <= 1'b0;
`ifdef BITMAP_ENC_ZERO_REPORT_EN
                        out_zero_q  <= 1'b0;
`endif
                    end else if (out_ready) begin
                        pending_q  <= remaining;
                        out_q      <= rem_idx;
                        out_last_q <= rem_single;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = rst_n && en && (state_q == IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == EMIT);
`ifdef BITMAP_ENC_ZERO_REPORT_EN
    assign out_zero  = out_zero_q;
`else
    assign out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_bitmap_encoder8.sv
// Testbench for bitmap_encoder8: two instances (low-first and high-first) share stimulus.
// Expected beats are queued on each accepted bitmap; a negedge monitor compares every presented beat.
// Directed scenarios first, then randomized traffic with random stalls and enable drops.
module tb_bitmap_encoder8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] in_d;
    logic       in_valid;
    logic       out_ready;

    logic       ir0, ov0, ol0, oz0, b0;
    logic [2:0] o0;
    logic       ir1, ov1, ol1, oz1, b1;
    logic [2:0] o1;

    always #5 clk = ~clk;

    bitmap_encoder8 #(.HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_d), .in_valid(in_valid), .in_ready(ir0),
        .out(o0), .out_valid(ov0), .out_ready(out_ready), .out_last(ol0), .out_zero(oz0), .busy(b0)
    );

    bitmap_encoder8 #(.HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_d), .in_valid(in_valid), .in_ready(ir1),
        .out(o1), .out_valid(ov1), .out_ready(out_ready), .out_last(ol1), .out_zero(oz1), .busy(b1)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the set indices of the bitmap in ascending / descending order, last flag on the final one.
    task automatic model_push(input logic [7:0] bm);
        int    ones[$];
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            if (bm[i]) ones.push_back(i);
        end
        if (ones.size() == 0) begin
`ifdef BITMAP_ENC_ZERO_REPORT_EN
            b.idx = 3'd0; b.last = 1'b1; b.zero = 1'b1;
            q0.push_back(b);
            q1.push_back(b);
`endif
        end else begin
            for (int k = 0; k < ones.size(); k++) begin
                b.last = (k == ones.size() - 1);
                b.zero = 1'b0;
                b.idx  = 3'(ones[k]);
                q0.push_back(b);
                b.idx  = 3'(ones[ones.size() - 1 - k]);
                q1.push_back(b);
            end
        end
    endtask

    task automatic check_inst(input string tag, input bit have, input beat_t head,
                              input logic [2:0] o, input logic ov, input logic ol,
                              input logic oz, input logic b, input logic ir);
        chk({tag, "_vld"}, int'(ov), int'(have));
        chk({tag, "_busy"}, int'(b), int'(have));
        chk({tag, "_in_ready"}, int'(ir), int'(!have && en));
        if (ov && have) begin
            chk({tag, "_idx"}, int'(o), int'(head.idx));
            chk({tag, "_last"}, int'(ol), int'(head.last));
            chk({tag, "_zero"}, int'(oz), int'(head.zero));
        end else if (!ov) begin
            chk({tag, "_idle_outs"}, int'({o, ol, oz}), 0);
        end
    endtask

    // Scoreboard monitor: compare presented beats, then advance the model for the coming edge.
    always @(negedge clk) begin
        beat_t h0, h1;
        bit    have;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            chk("reset_outs_lo", int'({o0, ov0, ol0, oz0, b0, ir0}), 0);
            chk("reset_outs_hi", int'({o1, ov1, ol1, oz1, b1, ir1}), 0);
        end else begin
            have = (q0.size() != 0);
            h0   = have ? q0[0] : '0;
            h1   = (q1.size() != 0) ? q1[0] : '0;
            check_inst("lo", have, h0, o0, ov0, ol0, oz0, b0, ir0);
            check_inst("hi", (q1.size() != 0), h1, o1, ov1, ol1, oz1, b1, ir1);
            if (have) begin
                if (!en) begin
                    q0.delete();
                    q1.delete();
                end else if (out_ready) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end else if (en && in_valid) begin
                model_push(in_d);
            end
        end
    end

    task automatic send(input logic [7:0] bm);
        bit ok;
        ok       = 1'b0;
        in_d     = bm;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (ir0) ok = 1'b1;
        end
        if (!ok) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (q0.size() == 0 && !ov0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        in_d      = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mixed bitmap, ready held high: 2,5,7 low-first / 7,5,2 high-first.
        send(8'b1010_0100);
        wait_idle();
        chk("after_a4_in_ready", int'(ir0), 1);

        // Full bitmap with ready toggling every cycle.
        out_ready = 1'b0;
        send(8'hFF);
        for (int c = 0; c < 40 && q0.size() != 0; c++) begin
            out_ready = (c % 2 == 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle();

        // Enable dropped after the first beat is consumed.
        send(8'h81);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_vld_lo", int'(ov0), 0);
        chk("abort_vld_hi", int'(ov1), 0);
        chk("abort_in_ready_en0", int'(ir0), 0);
        en = 1'b1;
        #1;
        chk("abort_in_ready_en1", int'(ir0), 1);
        @(posedge clk);
        #1;

        // Reset mid-stream, then a fresh single-bit bitmap.
        send(8'h0F);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lo", int'({o0, ov0, ol0, oz0, b0, ir0}), 0);
        chk("async_rst_hi", int'({o1, ov1, ol1, oz1, b1, ir1}), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h10);
        wait_idle();

        // All-zero bitmap.
        send(8'h00);
        wait_idle();
        chk("after_zero_in_ready", int'(ir0), 1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_d      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            en        = ($urandom_range(0, 19) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        wait_idle();
        chk("final_queue_empty", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bitmap_encoder8.md
BITMAP_ENCODER8 -- requirements
Module: bitmap_encoder8

Interface
REQ-001 SHALL have parameter HIGH_FIRST, default 0; 0 = lowest set index emitted first, 1 = highest set index emitted first.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  block enable.
REQ-005 SHALL have port in  input  8  request bitmap to encode.
REQ-006 SHALL have port in_valid  input  1  bitmap offered.
REQ-007 SHALL have port in_ready  output  1  bitmap accepted when in_valid & in_ready at a clk edge.
REQ-008 SHALL have port out  output  3  encoded index of current beat.
REQ-009 SHALL have port out_valid  output  1  beat present.
REQ-010 SHALL have port out_ready  input  1  beat consumed when out_valid & out_ready at a clk edge.
REQ-011 SHALL have port out_last  output  1  current beat is final beat of its bitmap.
REQ-012 SHALL have port out_zero  output  1  current beat reports an all-zero bitmap.
REQ-013 SHALL have port busy  output  1  high whenever state is EMIT.

Function
REQ-014 SHALL implement states IDLE and EMIT, plus an internal 8-bit pending register.
REQ-015 in_ready SHALL be combinational: 1 only when state = IDLE and en = 1.
REQ-016 IDLE, accept of nonzero bitmap: pending <= in, state -> EMIT; first beat has out_valid = 1 in the cycle after the accept edge (latency 1).
REQ-017 EMIT: out SHALL be the index of the lowest (HIGH_FIRST=0) or highest (HIGH_FIRST=1) set bit of pending; out_last = 1 iff pending has exactly one bit set.
REQ-018 EMIT, beat consumed: that bit SHALL be cleared in pending; if out_last, state -> IDLE and out_valid = 0 next cycle; otherwise the next beat appears next cycle.
REQ-019 While out_valid = 1 and out_ready = 0, out, out_last and out_zero SHALL be held stable.
REQ-020 With out_ready held high, a bitmap of k set bits SHALL produce k beats on k consecutive cycles, followed by one IDLE cycle before the next accept (in_ready = 0 throughout EMIT).
REQ-021 en = 0 in EMIT SHALL abort: pending cleared, state -> IDLE, and out_valid = 0 at the next edge regardless of out_ready; no further beats from that bitmap.
REQ-022 en = 0 in IDLE SHALL hold in_ready = 0; in_valid is ignored.
REQ-023 out, out_valid, out_last and out_zero SHALL be registered outputs, with out = 0, out_last = 0 and out_zero = 0 whenever out_valid = 0.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, pending = 0, out = 0, out_valid = 0, out_last = 0, out_zero = 0 and busy = 0, independent of clk.
REQ-025 Reset asserted mid-EMIT SHALL discard the pending bitmap; the first accept after reset release SHALL behave as from power-up.
REQ-026 in_ready SHALL be 0 while rst_n = 0.

Configuration
REQ-027 The macro BITMAP_ENC_ZERO_REPORT_EN SHALL control handling of all-zero bitmaps.
REQ-028 With BITMAP_ENC_ZERO_REPORT_EN defined, an accepted bitmap of 0 SHALL produce exactly one beat with out = 0, out_zero = 1 and out_last = 1, following normal EMIT handshake and latency.
REQ-029 Without BITMAP_ENC_ZERO_REPORT_EN, an accepted bitmap of 0 SHALL be consumed silently: state stays IDLE, no beat is produced, and out_zero is tied to 0.

Verification
REQ-030 HIGH_FIRST=0, en=1, out_ready=1, accept in=8'b1010_0100 -> beats out=2,5,7 on consecutive cycles, out_last only on 7, in_ready back to 1 one cycle later.
REQ-031 HIGH_FIRST=1, accept 8'hFF, out_ready toggling 1/0 each cycle -> out=7..0 each held while stalled, 8 beats total, out_last only on 0.
REQ-032 Accept 8'h81, drop en after first beat consumed -> out_valid=0 next cycle, index 7 never emitted, in_ready=1 once en returns.
REQ-033 Accept 8'h0F, assert rst_n=0 mid-stream -> all outputs 0 immediately; after release, accept 8'h10 -> single beat out=4, out_last=1.
REQ-034 Accept 8'h00 -> with macro: one beat out=0, out_zero=1, out_last=1; without macro: no beat, in_ready stays 1.
